// File: rtl/line_buffer_kxk.sv
`default_nettype none
// ============================================================================
// line_buffer_kxk : streaming KxK window generator with K-1 line memories,
//                   stride gating, valid/ready output slice and frame resync.
// Revision 1.0
// ============================================================================
module line_buffer_kxk #(
  parameter int DATA_BITS = 24,
  parameter int IMG_W     = 24,
  parameter int IMG_H     = 24,
  parameter int K         = 2,
  parameter int STRIDE    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_BITS-1:0]       data_in,
  input  logic                       valid_in,
  input  logic                       sof_in,
  output logic                       in_ready,
  output logic [K*K*DATA_BITS-1:0]   window,
  output logic                       window_valid,
  input  logic                       out_ready,
  output logic                       frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int WB = K * K * DATA_BITS;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  logic [DATA_BITS-1:0] line_q [0:K-2][0:IMG_W-1];
  logic [DATA_BITS-1:0] column [0:K-1];

  logic [CW-1:0] col_cnt_q, col_cnt_d, col_eff;
  logic [RW-1:0] row_cnt_q, row_cnt_d, row_eff;
  logic [PW-1:0] col_ph_q, col_ph_d, col_ph_eff;
  logic [PW-1:0] row_ph_q, row_ph_d, row_ph_eff;
  logic [WB-1:0] shreg_q, shreg_d;
  logic [WB-1:0] window_q, window_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, col_wrap, row_wrap, qualify;

  assign in_ready = out_ready || !win_valid_q;
  assign accept   = valid_in && in_ready;

  // A start-of-frame pixel is evaluated as (0,0) regardless of the counters.
  assign col_eff    = sof_in ? '0 : col_cnt_q;
  assign row_eff    = sof_in ? '0 : row_cnt_q;
  assign col_ph_eff = (col_eff == COL_FIRST) ? '0 : col_ph_q;
  assign row_ph_eff = (row_eff == ROW_FIRST) ? '0 : row_ph_q;
  assign col_wrap   = (col_eff == COL_LAST);
  assign row_wrap   = (row_eff == ROW_LAST);
  assign qualify    = (row_eff >= ROW_FIRST) && (col_eff >= COL_FIRST) &&
                      (row_ph_eff == '0) && (col_ph_eff == '0);

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      column[r] = line_q[K-2-r][col_eff];
    end
    column[K-1] = data_in;
  end

  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          shreg_d[(r*K+c)*DATA_BITS +: DATA_BITS] = shreg_q[(r*K+c+1)*DATA_BITS +: DATA_BITS];
        end
        shreg_d[(r*K+K-1)*DATA_BITS +: DATA_BITS] = column[r];
      end
    end
  end

  // Phases are written back already resolved so a forced zero persists for the row.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    col_ph_d  = col_ph_q;
    row_ph_d  = row_ph_q;
    if (accept) begin
      col_cnt_d = col_wrap ? '0 : col_eff + 1'b1;
      col_ph_d  = (col_ph_eff == PH_LAST) ? '0 : col_ph_eff + 1'b1;
      row_cnt_d = row_eff;
      row_ph_d  = row_ph_eff;
      if (col_wrap) begin
        row_cnt_d = row_wrap ? '0 : row_eff + 1'b1;
        row_ph_d  = (row_ph_eff == PH_LAST) ? '0 : row_ph_eff + 1'b1;
      end
    end
  end

  always_comb begin
    win_valid_d  = win_valid_q;
    window_d     = window_q;
    frame_done_d = accept && col_wrap && row_wrap;
    if (accept && qualify) begin
      win_valid_d = 1'b1;
      window_d    = shreg_d;
    end else if (out_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      col_ph_q     <= '0;
      row_ph_q     <= '0;
      shreg_q      <= '0;
      window_q     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_ph_q     <= col_ph_d;
      row_ph_q     <= row_ph_d;
      shreg_q      <= shreg_d;
      window_q     <= window_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      line_q[0][col_eff] <= data_in;
      for (int m = 1; m < K - 1; m++) begin
        line_q[m][col_eff] <= line_q[m-1][col_eff];
      end
    end
  end

  assign window       = window_q;
  assign window_valid = win_valid_q;
  assign frame_done   = frame_done_q;

endmodule
`default_nettype wire
